// File: rtl/nibble_add_sequencer.sv
// rtl/nibble_add_sequencer.sv - nibble-serial add/subtract sequencer driving a shared external 4-bit adder
module nibble_add_sequencer #(
    parameter int NIBBLES = 4,
    parameter int SETTLE  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin_in,
    input  logic                   sub,
    output logic [3:0]             add_x,
    output logic [3:0]             add_y,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   res_cout,
    output logic                   res_ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            carry;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cnt;

    logic [W-1:0]    b_in;
    logic            c_in;
    logic [IW-1:0]   nxt_idx;
    logic [3:0]      a_nxt;
    logic [3:0]      b_nxt;
    logic            last_nib;
    logic            settled;

    // Operand conditioning at accept time and selection of the next nibble to present
    always_comb begin
        b_in     = sub ? ~b : b;
        c_in     = sub ? 1'b1 : cin_in;
        nxt_idx  = idx + 1'b1;
        last_nib = (idx == IW'(NIBBLES - 1));
        settled  = (cnt == CW'(SETTLE - 1));
        a_nxt    = '0;
        b_nxt    = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (nxt_idx == IW'(k)) begin
                a_nxt = a_r[4*k +: 4];
                b_nxt = b_r[4*k +: 4];
            end
        end
    end

    // Control FSM; adder inputs are registered so they stay stable across the whole settle window
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            res_valid   <= 1'b0;
            result      <= '0;
            res_cout    <= 1'b0;
            res_ovf     <= 1'b0;
            add_x       <= '0;
            add_y       <= '0;
            add_cin     <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            carry       <= 1'b0;
            idx         <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        a_r         <= a;
                        b_r         <= b_in;
                        carry       <= c_in;
                        result      <= '0;
                        idx         <= '0;
                        cnt         <= '0;
                        // Nibble 0 is presented from the accept edge onward
                        add_x       <= a[3:0];
                        add_y       <= b_in[3:0];
                        add_cin     <= c_in;
                        start_ready <= 1'b0;
                        state       <= STEP;
                    end
                end
                STEP: begin
                    if (settled) begin
                        cnt   <= '0;
                        carry <= add_cout;
                        for (int k = 0; k < NIBBLES; k++) begin
                            if (idx == IW'(k)) begin
                                result[4*k +: 4] <= add_sum;
                            end
                        end
                        if (last_nib) begin
                            res_cout  <= add_cout;
                            res_ovf   <= (a_r[W-1] == b_r[W-1]) && (add_sum[3] != a_r[W-1]);
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx     <= nxt_idx;
                            add_x   <= a_nxt;
                            add_y   <= b_nxt;
                            add_cin <= add_cout;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        add_x       <= '0;
                        add_y       <= '0;
                        add_cin     <= 1'b0;
                        idx         <= '0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    start_ready <= 1'b1;
                    res_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb/tb_nibble_add_sequencer.sv - randomized self-checking bench for nibble_add_sequencer
module tb_nibble_add_sequencer;

    localparam int NIBBLES = 4;
    localparam int SETTLE  = 2;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin_in;
    logic         sub;
    logic [3:0]   add_x;
    logic [3:0]   add_y;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         res_cout;
    logic         res_ovf;

    logic [4:0]   add_res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Slow external adder: outputs settle 12 ns after inputs change (just over one clock period)
    assign #12 add_res = {1'b0, add_x} + {1'b0, add_y} + {4'b0, add_cin};
    assign add_sum  = add_res[3:0];
    assign add_cout = add_res[4];

    nibble_add_sequencer #(.NIBBLES(NIBBLES), .SETTLE(SETTLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin_in      (cin_in),
        .sub         (sub),
        .add_x       (add_x),
        .add_y       (add_y),
        .add_cin     (add_cin),
        .add_sum     (add_sum),
        .add_cout    (add_cout),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .res_cout    (res_cout),
        .res_ovf     (res_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_reset_values(input string tag);
        check({tag, "_start_ready"}, start_ready, 1);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_add_x"}, add_x, 0);
        check({tag, "_add_y"}, add_y, 0);
        check({tag, "_add_cin"}, add_cin, 0);
    endtask

    // Full operation: issue, watch nibble sequence and latency, optionally backpressure, then handshake
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_op,
                          input logic tsub, input logic tcin, input int hold);
        int          bm;
        int          c0;
        int          full;
        int          exp_res;
        int          exp_cout;
        int          exp_ovf;
        int          k;
        int          m;
        bit          seen;
        bm       = tsub ? (~int'(tb_op)) & 32'hFFFF : int'(tb_op);
        c0       = tsub ? 1 : int'(tcin);
        full     = int'(ta) + bm + c0;
        exp_res  = full & 32'hFFFF;
        exp_cout = (full >> 16) & 1;
        exp_ovf  = ((ta[15] == bm[15]) && (exp_res[15] != ta[15])) ? 1 : 0;

        @(negedge clk);
        a = ta; b = tb_op; sub = tsub; cin_in = tcin; start_valid = 1'b1;
        check("start_ready_before_accept", start_ready, 1);
        @(posedge clk);
        seen = 1'b0;
        for (int s = 0; s < 40 && !seen; s++) begin
            @(negedge clk);
            start_valid = 1'b0;
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin_in = 1'($urandom);
            if (res_valid) begin
                seen = 1'b1;
                check("latency", s, NIBBLES * SETTLE);
            end else begin
                k = s / SETTLE;
                m = (1 << (4 * k)) - 1;
                check("add_x", add_x, (int'(ta) >> (4 * k)) & 15);
                check("add_y", add_y, (bm >> (4 * k)) & 15);
                check("add_cin", add_cin, (((int'(ta) & m) + (bm & m) + c0) >> (4 * k)) & 1);
                check("start_ready_busy", start_ready, 0);
            end
        end
        if (!seen) begin
            check("timeout_res_valid", 0, 1);
        end else begin
            check("result", result, exp_res);
            check("res_cout", res_cout, exp_cout);
            check("res_ovf", res_ovf, exp_ovf);
            for (int h = 0; h < hold; h++) begin
                start_valid = 1'b1;
                a = W'($urandom); b = W'($urandom);
                @(posedge clk);
                @(negedge clk);
                check("hold_result", result, exp_res);
                check("hold_res_cout", res_cout, exp_cout);
                check("hold_res_ovf", res_ovf, exp_ovf);
                check("hold_start_ready", start_ready, 0);
                check("hold_res_valid", res_valid, 1);
            end
            start_valid = 1'b0;
            res_ready   = 1'b1;
            @(posedge clk);
            @(negedge clk);
            res_ready = 1'b0;
            check("post_hs_res_valid", res_valid, 0);
            check("post_hs_start_ready", start_ready, 1);
            check("post_hs_add_x", add_x, 0);
            check("post_hs_result_kept", result, exp_res);
        end
    endtask

    initial begin
        rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
        a = '0; b = '0; cin_in = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_reset_values("reset");
        check("reset_res_cout", res_cout, 0);
        check("reset_res_ovf", res_ovf, 0);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0);
        run_op(16'hABCD, 16'h1111, 1'b0, 1'b1, 5);

        // Abort during nibble 2, then confirm no carry or partial result survives
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin_in = 1'b1; start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2 * SETTLE) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_reset_values("abort");
        run_op(16'h000F, 16'h0001, 1'b0, 1'b0, 0);

        for (int i = 0; i < 16; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_add_sequencer.md
# nibble_add_sequencer

Sequencer that performs a 4·NIBBLES-bit add or subtract using a single external 4-bit ripple-carry adder, one nibble per step, LSB nibble first. It holds the carry between steps and waits SETTLE clock periods per nibble for the gate-delayed adder outputs to settle. Operands arrive over a valid/ready request port, and the result leaves over a valid/ready response port. The block sits between the arithmetic-issue logic and the shared `four_bit_adder` instance, and is the only driver of that adder's inputs.

## Interface
- NIBBLES, 4: operand width in nibbles; W = 4·NIBBLES; ≥1.
- SETTLE, 2: clock periods each nibble is presented to the adder before sampling; ≥1.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  request valid.
- start_ready  out  1  request ready; high only in IDLE.
- a  in  W  operand A.
- b  in  W  operand B.
- cin_in  in  1  carry-in for add; ignored when sub=1.
- sub  in  1  1 = compute a − b (b inverted, carry-in 1).
- add_x  out  4  to adder x.
- add_y  out  4  to adder y.
- add_cin  out  1  to adder cin.
- add_sum  in  4  from adder sum.
- add_cout  in  1  from adder cout.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- result  out  W  sum/difference.
- res_cout  out  1  final carry (sub: 1 = no borrow).
- res_ovf  out  1  two's-complement overflow.

## Operation
- Reset values: state IDLE, start_ready 1, res_valid 0, result 0, res_cout 0, res_ovf 0, add_x 0, add_y 0, add_cin 0, nibble index 0, settle count 0.
- The FSM has three states: IDLE, STEP, DONE.
- IDLE:
  - On start_valid && start_ready: register a_r=a, b_r = sub ? ~b : b, carry = sub ? 1 : cin_in; clear result; set idx=0, cnt=0; go to STEP.
  - With start_valid low, the block stays in IDLE.
- STEP:
  - add_x = a_r[4·idx+3:4·idx], add_y = b_r[same], add_cin = carry. These are registered and stable for the whole step.
  - cnt increments each cycle.
  - On the edge where cnt == SETTLE−1: result[4·idx+3:4·idx] ← add_sum; carry ← add_cout; cnt ← 0.
    - If idx == NIBBLES−1: go to DONE, with res_cout ← add_cout and res_ovf ← (a_r[W−1]==b_r[W−1]) && (add_sum[3]!=a_r[W−1]).
    - Otherwise idx increments and the next nibble is driven from the following cycle.
- DONE:
  - res_valid=1. result, res_cout and res_ovf are held stable until res_ready.
  - On res_valid && res_ready: go to IDLE, res_valid←0, adder inputs←0. result keeps its last value.
- start_valid is ignored outside IDLE; a/b/sub/cin_in are sampled only on acceptance.
- The add is modulo 2^W; carry out of the top nibble appears only on res_cout.
- rst high on any edge, in any state, aborts the operation. The block returns to reset values on that edge, and a partial result is discarded.

## Timing
- Accept on edge E0 → res_valid is high from edge E0 + NIBBLES·SETTLE (default 8 cycles).
- Nibble k is driven from edge E0 + k·SETTLE and sampled at E0 + (k+1)·SETTLE.
- The adder path add_x/add_y/add_cin → add_sum/add_cout is a multicycle path of SETTLE periods. Choose SETTLE·Tclk > worst-case adder delay (full carry ripple, about 65 ns with the current gate delays).
- Minimum request-to-request spacing is NIBBLES·SETTLE + 2 cycles: the DONE handshake cycle plus the IDLE accept cycle.
- No combinational path exists from start_valid or res_ready to any output.

## Test plan
- Reset, then idle 3 cycles → start_ready=1, res_valid=0, result=0, add_x/add_y/add_cin=0.
- NIBBLES=4, SETTLE=2; a=0x1234, b=0x4321, sub=0, cin_in=0 → result=0x5555, res_cout=0, res_ovf=0; res_valid rises exactly 8 cycles after accept; add_x sequence is 4,3,2,1, each held 2 cycles.
- a=0xFFFF, b=0x0001, cin_in=0 → result=0x0000, res_cout=1, res_ovf=0 (carry propagated through all nibbles). a=0x7FFF, b=0x0001 → result=0x8000, res_cout=0, res_ovf=1.
- sub=1: a=0x0005, b=0x0007 → result=0xFFFE, res_cout=0, res_ovf=0. a=0x8000, b=0x0001 → result=0x7FFF, res_cout=1, res_ovf=1. cin_in=1 must not change either result.
- Backpressure: hold res_ready=0 for 5 cycles in DONE while start_valid=1 with new operands → result stays stable, start_ready=0, and the new request is accepted only after the res_ready handshake.
- Assert rst for 1 cycle during nibble 2 → the next cycle shows IDLE reset values. A following request a=0x000F, b=0x0001 → result=0x0010, with no leftover carry.
